// File: rtl/calc_result_display_if.sv
// Capture/display bundle between the calculator and its 7-segment result display.
// Master drives the capture strobe and operands; slave returns the display outputs.
interface calc_result_display_if;
   logic       start;
   logic [4:0] answer;
   logic [2:0] remainder;
   logic [6:0] seg;
   logic       dp;
   logic [2:0] phase;

   modport master (
      output start, answer, remainder,
      input  seg, dp, phase
   );

   modport slave (
      input  start, answer, remainder,
      output seg, dp, phase
   );
endinterface

// File: rtl/calc_result_display.sv
// Captures a signed calculator result and remainder, then cycles sign, tens, units,
// remainder and a blank gap onto one 7-segment display, DWELL cycles per phase.
module calc_result_display #(
   parameter int unsigned DWELL = 1000
) (
   input logic                  clk,
   input logic                  reset,
   calc_result_display_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StSign  = 3'd1,
      StTens  = 3'd2,
      StUnits = 3'd3,
      StRem   = 3'd4,
      StGap   = 3'd5
   } state_t;

   localparam logic [15:0] LAST = 16'(DWELL - 1);

   state_t      state, nxt_state;
   logic [15:0] cnt, nxt_cnt;
   logic [4:0]  ans_q, nxt_ans;
   logic [2:0]  rem_q, nxt_rem;
   logic [6:0]  seg_q, nxt_seg;
   logic        dp_q;
   logic [5:0]  mag;
   logic        tens;
   logic [3:0]  units;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    seg_of = 7'h3F;
         4'd1:    seg_of = 7'h06;
         4'd2:    seg_of = 7'h5B;
         4'd3:    seg_of = 7'h4F;
         4'd4:    seg_of = 7'h66;
         4'd5:    seg_of = 7'h6D;
         4'd6:    seg_of = 7'h7D;
         4'd7:    seg_of = 7'h07;
         4'd8:    seg_of = 7'h7F;
         4'd9:    seg_of = 7'h6F;
         default: seg_of = 7'h00;
      endcase
   endfunction

   // Capture overrides any phase advance, so a strobe always restarts at SIGN.
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_ans   = ans_q;
      nxt_rem   = rem_q;
      if (bus.start) begin
         nxt_state = StSign;
         nxt_cnt   = '0;
         nxt_ans   = bus.answer;
         nxt_rem   = bus.remainder;
      end else if (state != StIdle) begin
         if (cnt == LAST) begin
            nxt_cnt = '0;
            case (state)
               StSign:  nxt_state = StTens;
               StTens:  nxt_state = StUnits;
               StUnits: nxt_state = StRem;
               StRem:   nxt_state = StGap;
               StGap:   nxt_state = StSign;
               default: nxt_state = StIdle;
            endcase
         end else begin
            nxt_cnt = cnt + 16'd1;
         end
      end
   end

   // Negation is 6 bits wide so that -16 gives a magnitude of 16.
   always_comb begin
      mag   = nxt_ans[4] ? (6'd0 - {1'b1, nxt_ans}) : {1'b0, nxt_ans};
      tens  = (mag >= 6'd10);
      units = tens ? 4'(mag - 6'd10) : mag[3:0];
      case (nxt_state)
         StSign:  nxt_seg = nxt_ans[4] ? 7'h40 : 7'h00;
         StTens:  nxt_seg = tens ? 7'h06 : 7'h00;
         StUnits: nxt_seg = seg_of(units);
         StRem:   nxt_seg = seg_of({1'b0, nxt_rem});
         default: nxt_seg = 7'h00;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= StIdle;
         cnt   <= '0;
         ans_q <= '0;
         rem_q <= '0;
         seg_q <= '0;
         dp_q  <= 1'b0;
      end else begin
         state <= nxt_state;
         cnt   <= nxt_cnt;
         ans_q <= nxt_ans;
         rem_q <= nxt_rem;
         seg_q <= nxt_seg;
         dp_q  <= (nxt_state == StRem);
      end
   end

   assign bus.seg   = seg_q;
   assign bus.dp    = dp_q;
   assign bus.phase = state;

endmodule

// File: tb/tb_calc_result_display.sv
// Scoreboard bench for calc_result_display: expected display frames are queued at each
// capture and popped one per clock.
module tb_calc_result_display;
   localparam int unsigned DWELL = 4;

   logic clk = 1'b0;
   logic reset;

   calc_result_display_if bus ();

   calc_result_display #(.DWELL(DWELL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] ph;
      logic [6:0] seg;
      logic       dp;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   total  = 0;
   int   passed = 0;
   logic [6:0] dig [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Expected frames for n cycles after a capture, derived with integer arithmetic.
   function automatic void push_phases(input string tag, input logic [4:0] a,
                                       input logic [2:0] r, input int n);
      int mag;
      int p;
      logic [6:0] c [6];
      mag  = a[4] ? 32 - int'(a) : int'(a);
      c[0] = 7'h00;
      c[1] = a[4] ? 7'h40 : 7'h00;
      c[2] = (mag >= 10) ? dig[1] : 7'h00;
      c[3] = dig[mag % 10];
      c[4] = dig[r];
      c[5] = 7'h00;
      for (int i = 0; i < n; i++) begin
         p = 1 + (i / DWELL) % 5;
         sb.push_back('{3'(p), c[p], (p == 4), tag});
      end
   endfunction

   function automatic void push_idle(input string tag, input int n);
      for (int i = 0; i < n; i++) sb.push_back('{3'd0, 7'h00, 1'b0, tag});
   endfunction

   task automatic go(input logic [4:0] a, input logic [2:0] r);
      bus.start     = 1'b1;
      bus.answer    = a;
      bus.remainder = r;
   endtask

   // One frame per clock; operands are scrambled between captures unless start is held.
   task automatic run(input int n, input bit hold);
      exp_t e;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (!hold) begin
            bus.start     = 1'b0;
            bus.answer    = 5'($urandom);
            bus.remainder = 3'($urandom);
         end
         if (sb.size() == 0) begin
            total++;
            $error("FAIL sb_empty observed=0 entries expected=1 entry");
         end else begin
            e = sb.pop_front();
            check({e.tag, "_phase"}, {5'd0, bus.phase}, {5'd0, e.ph});
            check({e.tag, "_seg"}, {1'b0, bus.seg}, {1'b0, e.seg});
            check({e.tag, "_dp"}, {7'd0, bus.dp}, {7'd0, e.dp});
         end
      end
   endtask

   initial begin
      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.answer    = '0;
      bus.remainder = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_phase", {5'd0, bus.phase}, 8'd0);
      check("rst_seg", {1'b0, bus.seg}, 8'h00);
      check("rst_dp", {7'd0, bus.dp}, 8'd0);
      reset = 1'b0;
      push_idle("idle0", 3);
      run(3, 1'b0);

      go(5'b11101, 3'd1);
      push_phases("neg3", 5'b11101, 3'd1, 40);
      run(40, 1'b0);

      go(5'b10000, 3'd0);
      push_phases("neg16", 5'b10000, 3'd0, 20);
      run(20, 1'b0);

      go(5'd12, 3'd7);
      push_phases("pos12", 5'd12, 3'd7, 20);
      run(20, 1'b0);

      go(5'd0, 3'd0);
      push_phases("zero", 5'd0, 3'd0, 20);
      run(20, 1'b0);

      // Re-capture on the edge ending UNITS cycle 2.
      go(5'd5, 3'd2);
      push_phases("pos5", 5'd5, 3'd2, 10);
      run(10, 1'b0);
      go(5'b11111, 3'd6);
      push_phases("recap", 5'b11111, 3'd6, 20);
      run(20, 1'b0);
      // Capture coincident with the GAP->SIGN edge.
      go(5'd9, 3'd3);
      push_phases("gapcap", 5'd9, 3'd3, 20);
      run(20, 1'b0);

      go(5'b10110, 3'd4);
      push_phases("hold", 5'b10110, 3'd4, 3);
      run(3, 1'b1);
      push_phases("hold_rel", 5'b10110, 3'd4, 20);
      run(20, 1'b0);

      go(5'd7, 3'd5);
      push_phases("pre_rst", 5'd7, 3'd5, 13);
      run(13, 1'b0);
      #2 reset = 1'b1;
      #1;
      check("async_rst_phase", {5'd0, bus.phase}, 8'd0);
      check("async_rst_seg", {1'b0, bus.seg}, 8'h00);
      check("async_rst_dp", {7'd0, bus.dp}, 8'd0);
      #2 reset = 1'b0;
      push_idle("idle_after_rst", 5);
      run(5, 1'b0);

      go(5'd3, 3'd0);
      push_phases("pos3", 5'd3, 3'd0, 20);
      run(20, 1'b0);

      check("sb_drain", 8'(sb.size()), 8'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/calc_result_display.md
# calc_result_display

Downstream stage of the 2-bit signed calculator. Captures the calculator's 5-bit two's-complement `answer` and 3-bit `remainder` on a `start` strobe. Converts them to sign and decimal digits, then time-multiplexes them onto a single 7-segment display. Each display phase lasts `DWELL` clock cycles, and the sequence loops until the next capture or reset.

## Interface
- `DWELL`, default 1000: clock cycles per display phase; legal range is 1 to 2^16−1.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high; clears all state immediately.
- `start` input, 1 bit: capture strobe, sampled on the rising edge of `clk`.
- `answer` input, 5 bits: calculator result, two's complement, range −16..15.
- `remainder` input, 3 bits: calculator remainder, unsigned, range 0..7.
- `seg` output, 7 bits: {g,f,e,d,c,b,a}, active-high segments, registered.
- `dp` output, 1 bit: decimal point, active-high, registered.
- `phase` output, 3 bits: current state encoding, for visibility and verification.

## Operation
- States and `phase` encodings:
  - IDLE = 0
  - SIGN = 1
  - TENS = 2
  - UNITS = 3
  - REM = 4
  - GAP = 5
- Capture: on an edge with `start`=1:
  - Latch `answer` and `remainder` into internal registers.
  - Go to SIGN and clear the dwell counter.
  - This applies from any state, including mid-phase; a new capture always restarts the sequence.
- Magnitude: mag = answer[4] ? (−answer, computed 6-bit wide) : answer. Range is 0..16.
  - −16 must yield mag = 16; 5-bit wrap is not acceptable.
- Digits: tens = (mag ≥ 10) ? 1 : 0; units = mag − 10×tens.
- Phase content:
  - IDLE: `seg`=0x00.
  - SIGN: 0x40 ("−") if answer[4] is set, else 0x00.
  - TENS: digit "1" if tens=1, else 0x00 (leading-zero blanking).
  - UNITS: units digit, always shown, including "0".
  - REM: remainder digit with `dp`=1.
  - GAP: 0x00.
- `dp`=1 only in REM.
- Digit codes:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66
  - 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F
- Transitions: SIGN→TENS→UNITS→REM→GAP→SIGN, looping indefinitely on the captured values.
- IDLE is left only by `start`.
- Inputs are ignored except on edges where `start`=1. Changes on `answer`/`remainder` between captures do not affect the display.

## Timing
- Reset values, asynchronous and immediate:
  - state=IDLE, `phase`=0
  - `seg`=0x00, `dp`=0
  - dwell counter=0, captured registers=0
- Reset asserted mid-sequence returns all of the above at once. After reset deasserts, the block stays in IDLE until `start`.
- Capture edge N:
  - `phase`=1 and SIGN content on `seg` are visible after edge N (1-cycle latency).
- Dwell counter behaviour:
  - Increments each cycle in a non-IDLE state.
  - At count `DWELL`−1 it wraps to 0 and the state advances on the same edge.
  - Each phase therefore holds exactly `DWELL` cycles; a full loop is 5×`DWELL` cycles.
- `DWELL`=1: the phase advances every cycle.
- `start` on the same edge as a phase advance: capture wins, so the next state is SIGN and the counter is 0.
- `start` held high for consecutive cycles: the block re-captures each cycle and remains in SIGN with the counter at 0.
- `seg`, `dp` and `phase` all change on the same edge; no glitch paths from combinational inputs to outputs.

## Test plan
- Use `DWELL`=4 for every scenario.
- Negative single digit:
  - Stimulus: reset, then `start` with answer=5'b11101 (−3), remainder=1.
  - Required: `seg` = 0x40, 0x00, 0x4F, 0x06 (with `dp`=1), 0x00, for 4 cycles each. The sequence then repeats from 0x40.
- Wrap boundary:
  - Stimulus: answer=5'b10000 (−16), remainder=0.
  - Required: 0x40, 0x06, 0x7D, 0x3F (with `dp`=1), 0x00.
- Positive two digit:
  - Stimulus: answer=5'd12, remainder=7.
  - Required: 0x00, 0x06, 0x5B, 0x07 (with `dp`=1), 0x00.
- Zero:
  - Stimulus: answer=0, remainder=0.
  - Required: 0x00, 0x00, 0x3F, 0x3F (with `dp`=1), 0x00.
  - Check that UNITS is not blanked.
- Re-capture mid-phase:
  - Stimulus: during UNITS cycle 2 of answer=5, assert `start` with answer=5'b11111 (−1).
  - Required: next cycle `phase`=1, `seg`=0x40; SIGN then holds 4 full cycles. Also check `start` coincident with the GAP→SIGN edge.
- Reset mid-operation and idle:
  - Stimulus: assert `reset` asynchronously during REM, then deassert it.
  - Required: `seg`=0x00, `dp`=0, `phase`=0 immediately, with no clock edge needed. These values hold until `start`.
  - Also check that changing `answer` without `start` leaves `seg` unchanged.
